hamming_serial_rx: RTL and testbench

- Receive end of the Hamming(7,4) link. Accepts codewords bit-serially (LSB first, framed by a start-of-frame strobe), deserializes them and computes the 3-bit syndrome.
- Corrects any single-bit error, then presents the 4-bit data, the fixed codeword and the syndrome on a valid/ready output port.
- Sits downstream of the parallel encoder and the serializer, replacing the parallel-in decoder on the serial link.
- Keeps a saturating count of corrected codewords.

---
 rtl/hamming_serial_rx.sv | 130 +++++++++++++
 tb/tb_hamming_serial_rx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_serial_rx.sv
// Hamming(7,4) serial receiver.
// Collects a 7-bit codeword LSB first, framed by a start-of-frame strobe.
// It then corrects any single-bit error and presents the result on a
// valid/ready port.
// Double errors are not detected: they miscorrect, as Hamming(7,4) does.
module hamming_serial_rx #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_sof,
  output logic             sin_ready,
  output logic [3:0]       data,
  output logic [6:0]       fixed_codeword,
  output logic [2:0]       syndrome,
  output logic             err_corrected,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_abort,
  output logic [CNT_W-1:0] corr_count
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t             state_q;
  logic [2:0]         bit_cnt_q;
  logic [5:0]         shreg_q;
  logic [3:0]         data_q;
  logic [6:0]         fixed_q;
  logic [2:0]         syn_q;
  logic               err_q;
  logic               out_valid_q;
  logic               abort_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               last_bit;
  logic               complete;
  logic [6:0]         cw_d;
  logic [2:0]         syn_d;
  logic [6:0]         flip_d;
  logic [6:0]         fixed_d;

  // The final bit is held off only when it would overwrite a word the
  // consumer has not taken yet. A sof on the last slot restarts the frame.
  assign last_bit  = (state_q == COLLECT) && (bit_cnt_q == 3'd6);
  assign sin_ready = !(last_bit && out_valid_q && !out_ready);
  assign accept    = sin_valid && sin_ready;
  assign complete  = accept && last_bit && !sin_sof;

  // The incoming bit is cw[6]; the six stored bits supply cw[5:0].
  assign cw_d = {sin, shreg_q};

  // Syndrome from the parity-check masks; a nonzero value S names bit S-1.
  always_comb begin
    syn_d  = {^(cw_d & 7'b1111000), ^(cw_d & 7'b1100110), ^(cw_d & 7'b1010101)};
    flip_d = '0;
    if (syn_d != 3'd0) begin
      flip_d[syn_d - 3'd1] = 1'b1;
    end
    fixed_d = cw_d ^ flip_d;
  end

  // Frame collection FSM with registered output word, handshake and counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      fixed_q     <= '0;
      syn_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      abort_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      abort_q <= 1'b0;
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (sin_sof) begin
              shreg_q[0] <= sin;
              bit_cnt_q  <= 3'd1;
              state_q    <= COLLECT;
            end
          end
          COLLECT: begin
            if (sin_sof) begin
              abort_q    <= 1'b1;
              shreg_q[0] <= sin;
              bit_cnt_q  <= 3'd1;
            end else if (bit_cnt_q == 3'd6) begin
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              shreg_q[bit_cnt_q] <= sin;
              bit_cnt_q          <= bit_cnt_q + 3'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      if (complete) begin
        data_q      <= {fixed_d[6], fixed_d[5], fixed_d[4], fixed_d[2]};
        fixed_q     <= fixed_d;
        syn_q       <= syn_d;
        err_q       <= (syn_d != 3'd0);
        out_valid_q <= 1'b1;
        if ((syn_d != 3'd0) && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign data           = data_q;
  assign fixed_codeword = fixed_q;
  assign syndrome       = syn_q;
  assign err_corrected  = err_q;
  assign out_valid      = out_valid_q;
  assign frame_abort    = abort_q;
  assign corr_count     = cnt_q;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Bench for hamming_serial_rx.
// Two instances share the stimulus: CNT_W=8 and CNT_W=2, the second for counter saturation.
// Expected words come from a constant table or from a position-XOR Hamming model.
module tb_hamming_serial_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       sin, sin_valid, sin_sof, out_ready;
  logic       sin_ready1, sin_ready2;
  logic [3:0] data1, data2;
  logic [6:0] fixed1, fixed2;
  logic [2:0] syn1, syn2;
  logic       err1, err2, out_valid1, out_valid2, frame_abort1, frame_abort2;
  logic [7:0] corr_count1;
  logic [1:0] corr_count2;

  always #5 clk = ~clk;

  hamming_serial_rx #(.CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sin_sof(sin_sof),
    .sin_ready(sin_ready1), .data(data1), .fixed_codeword(fixed1), .syndrome(syn1),
    .err_corrected(err1), .out_valid(out_valid1), .out_ready(out_ready),
    .frame_abort(frame_abort1), .corr_count(corr_count1));

  hamming_serial_rx #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sin_sof(sin_sof),
    .sin_ready(sin_ready2), .data(data2), .fixed_codeword(fixed2), .syndrome(syn2),
    .err_corrected(err2), .out_valid(out_valid2), .out_ready(out_ready),
    .frame_abort(frame_abort2), .corr_count(corr_count2));

  typedef struct {
    logic [3:0] data;
    logic [6:0] fixed;
    logic [2:0] syn;
    logic       err;
    int         cnt1;
    int         cnt2;
  } exp_t;

  typedef struct {
    logic [6:0] cw;
    logic [3:0] data;
    logic [2:0] syn;
    logic [6:0] fixed;
  } vec_t;

  exp_t q[$];
  vec_t vecs[10];
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 0;
  bit   rnd_en = 0;
  bit   exp_abort = 0;
  bit   mf_active = 0;
  int   mf_cnt = 0;
  int   c1 = 0;
  int   c2 = 0;
  logic rdy_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: syndrome is the XOR of the 1-based positions of all set bits.
  function automatic exp_t model(input logic [6:0] cw);
    exp_t e;
    int s;
    logic [6:0] f;
    s = 0;
    f = cw;
    for (int i = 0; i < 7; i++) if (cw[i]) s ^= (i + 1);
    if (s != 0) f[s-1] = ~f[s-1];
    e.fixed = f;
    e.syn   = s[2:0];
    e.err   = (s != 0);
    e.data  = {f[6], f[5], f[4], f[2]};
    e.cnt1  = 0;
    e.cnt2  = 0;
    return e;
  endfunction

  // Parity bits chosen so the position-XOR of the whole word is zero.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] cw;
    int s;
    cw = '0;
    cw[2] = d[0]; cw[4] = d[1]; cw[5] = d[2]; cw[6] = d[3];
    s = 0;
    for (int i = 0; i < 7; i++) if (cw[i]) s ^= (i + 1);
    cw[0] = s[0]; cw[1] = s[1]; cw[3] = s[2];
    return cw;
  endfunction

  task automatic monitor();
    chk("frame_abort", frame_abort1, exp_abort);
    chk("frame_abort_w2", frame_abort2, exp_abort);
    exp_abort = 0;
    if (q.size() == 0) begin
      chk("idle_out_valid", out_valid1, 0);
      chk("idle_out_valid_w2", out_valid2, 0);
    end else begin
      chk("out_valid", out_valid1, 1);
      chk("out_valid_w2", out_valid2, 1);
      chk("data", data1, q[0].data);
      chk("fixed_codeword", fixed1, q[0].fixed);
      chk("syndrome", syn1, q[0].syn);
      chk("err_corrected", err1, q[0].err);
      chk("corr_count", corr_count1, q[0].cnt1);
      chk("data_w2", data2, q[0].data);
      chk("corr_count_w2", corr_count2, q[0].cnt2);
      if (out_valid1 && out_ready) q.delete(0);
    end
  endtask

  // One clock: check outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    rdy_s = sin_ready1;
    if (chk_en) monitor();
    @(posedge clk);
    #1;
    if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input exp_t e);
    exp_t x;
    x = e;
    if (x.syn != 0) begin
      if (c1 < 255) c1++;
      if (c2 < 3) c2++;
    end
    x.cnt1 = c1;
    x.cnt2 = c2;
    q.push_back(x);
  endtask

  task automatic send_bit(input logic b, input logic sof);
    bit ok;
    ok = 0;
    sin = b; sin_sof = sof; sin_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      tick();
      if (rdy_s) ok = 1;
    end
    if (!ok) chk("sin_ready_wait", rdy_s, 1);
    if (sof) begin
      exp_abort = mf_active;
      mf_active = 1;
      mf_cnt = 1;
    end else if (mf_active) begin
      mf_cnt++;
      if (mf_cnt == 7) mf_active = 0;
    end
    sin_valid = 1'b0; sin_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] cw, input exp_t e);
    for (int i = 0; i < 7; i++) send_bit(cw[i], i == 0);
    push(e);
  endtask

  task automatic do_reset();
    chk_en = 0;
    reset = 1'b0;
    q.delete();
    c1 = 0; c2 = 0; mf_active = 0; mf_cnt = 0; exp_abort = 0;
  endtask

  initial begin
    logic [6:0] cw, cwb;
    exp_t e;
    logic [3:0] d;
    int kind;
    int ep;
    int n;

    vecs[0] = '{7'b1010101, 4'b1011, 3'd0, 7'b1010101};
    vecs[1] = '{7'b1000101, 4'b1011, 3'd5, 7'b1010101};
    vecs[2] = '{7'h7E, 4'hF, 3'd1, 7'h7F};
    vecs[3] = '{7'h7D, 4'hF, 3'd2, 7'h7F};
    vecs[4] = '{7'h7B, 4'hF, 3'd3, 7'h7F};
    vecs[5] = '{7'h77, 4'hF, 3'd4, 7'h7F};
    vecs[6] = '{7'h6F, 4'hF, 3'd5, 7'h7F};
    vecs[7] = '{7'h5F, 4'hF, 3'd6, 7'h7F};
    vecs[8] = '{7'h3F, 4'hF, 3'd7, 7'h7F};
    vecs[9] = '{7'h00, 4'h0, 3'd0, 7'h00};

    sin = 0; sin_valid = 0; sin_sof = 0; out_ready = 0;
    do_reset();
    repeat (3) tick();
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_data", data1, 0);
    chk("rst_fixed", fixed1, 0);
    chk("rst_syndrome", syn1, 0);
    chk("rst_err", err1, 0);
    chk("rst_abort", frame_abort1, 0);
    chk("rst_count", corr_count1, 0);
    chk("rst_sin_ready", sin_ready1, 1);
    reset = 1'b1;
    chk_en = 1;
    tick();

    // Clean word with latency: valid appears right after bit 6 and lasts one cycle.
    out_ready = 1'b1;
    cw = 7'b1010101;
    for (int i = 0; i < 6; i++) send_bit(cw[i], i == 0);
    chk("lat_before_bit6", out_valid1, 0);
    send_bit(cw[6], 1'b0);
    chk("lat_after_bit6", out_valid1, 1);
    chk("lat_data", data1, 4'b1011);
    e = model(cw);
    push(e);
    tick();
    chk("lat_one_cycle", out_valid1, 0);
    chk("lat_count", corr_count1, 0);

    // Table: single error, syndrome sweep over 7'h7F, clean zero word.
    for (int i = 0; i < 10; i++) begin
      e.data = vecs[i].data; e.fixed = vecs[i].fixed; e.syn = vecs[i].syn;
      e.err = (vecs[i].syn != 0);
      send_frame(vecs[i].cw, e);
    end
    repeat (2) tick();
    chk("sweep_count", corr_count1, 8);

    // Backpressure: two frames with out_ready low; bit 6 of the second is stalled.
    out_ready = 1'b0;
    cw = encode(4'h3);
    send_frame(cw, model(cw));
    cwb = encode(4'hC) ^ 7'b0000100;
    for (int i = 0; i < 6; i++) send_bit(cwb[i], i == 0);
    sin = cwb[6]; sin_sof = 1'b0; sin_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_sin_ready_low", rdy_s, 0);
      chk("bp_hold_data", data1, 4'h3);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_sin_ready_high", rdy_s, 1);
    sin_valid = 1'b0;
    mf_active = 0; mf_cnt = 0;
    push(model(cwb));
    chk("bp_second_valid", out_valid1, 1);
    chk("bp_second_data", data1, 4'hC);
    chk("bp_second_syn", syn1, 3);
    tick();

    // Resync: four bits, then a fresh sof and a clean zero word; then stray bits.
    for (int i = 0; i < 4; i++) send_bit(i[0], i == 0);
    cw = 7'b0000000;
    send_bit(cw[0], 1'b1);
    chk("resync_abort_expected", exp_abort, 1);
    tick();
    chk("resync_abort_gone", frame_abort1, 0);
    for (int i = 1; i < 7; i++) send_bit(cw[i], 1'b0);
    push(model(cw));
    tick();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    repeat (3) tick();

    // Reset while a word is held and a frame is half received.
    out_ready = 1'b0;
    cw = encode(4'h9);
    send_frame(cw, model(cw));
    for (int i = 0; i < 3; i++) send_bit(1'b1, i == 0);
    do_reset();
    #1;
    chk("midrst_out_valid", out_valid1, 0);
    chk("midrst_count", corr_count1, 0);
    chk("midrst_sin_ready", sin_ready1, 1);
    repeat (2) tick();
    reset = 1'b1;
    chk_en = 1;
    out_ready = 1'b1;
    tick();
    cw = encode(4'h6);
    send_frame(cw, model(cw));
    tick();

    // Saturation: five corrected words; the 2-bit counter must stop at 3.
    for (int i = 0; i < 5; i++) begin
      cw = encode(4'(i + 1)) ^ (7'd1 << i);
      send_frame(cw, model(cw));
    end
    repeat (2) tick();
    chk("sat_count_w2", corr_count2, 3);
    chk("sat_count_w8", corr_count1, 5);

    // Random traffic with random backpressure, stray bits, aborts and double errors.
    rnd_en = 1;
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) send_bit(1'($urandom_range(0, 1)), 1'b0);
      end
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) tick();
      if (kind == 1) begin
        n = $urandom_range(1, 6);
        for (int j = 0; j < n; j++) send_bit(1'($urandom_range(0, 1)), j == 0);
      end
      d = 4'($urandom_range(0, 15));
      cw = encode(d);
      ep = $urandom_range(0, 8);
      if (ep < 7) cw[ep] = ~cw[ep];
      else if (ep == 8) cw = cw ^ 7'b0010010;
      send_frame(cw, model(cw));
    end
    rnd_en = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && q.size() != 0; k++) tick();
    chk("drain_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
